// File: rtl/temp_bcd_poller.sv
// rtl/temp_bcd_poller.sv - periodic LM75 temperature poller with sign + BCD conversion
//
// Purpose:
//   Pulses the I2C temperature-read FSM's start every POLL_DIV cycles and
//   captures its msb/lsb result on done. The 9-bit two's-complement reading
//   (0.5 degC LSB) becomes sign plus BCD hundreds/tens/ones/tenths. The
//   conversion uses an iterative double-dabble, one iteration per cycle.
//
// Optional feature:
//   TEMP_MINMAX_EN - when defined, tracks signed min/max raw readings.
//   When undefined, min_t/max_t are tied to zero and clr_minmax is ignored.
//
// Ports:
//   clk        in   system clock (shared with the I2C FSM)
//   rst        in   synchronous active-high reset
//   start      out  one-cycle pulse to the I2C FSM start
//   done_i     in   I2C FSM done (one-cycle pulse)
//   msb_i      in   I2C FSM msb
//   lsb_i      in   I2C FSM lsb (only bit 7 used)
//   clr_minmax in   clears min/max registers (TEMP_MINMAX_EN only)
//   sign       out  1 = negative reading
//   hund       out  BCD hundreds digit
//   tens       out  BCD tens digit
//   ones       out  BCD ones digit
//   tenths     out  BCD tenths digit (0 or 5)
//   valid      out  one-cycle pulse when digits update
//   timeout    out  one-cycle pulse when done_i fails to arrive before the next tick
//   busy       out  high whenever the FSM is not idle
//   min_t      out  lowest raw signed reading (TEMP_MINMAX_EN only)
//   max_t      out  highest raw signed reading (TEMP_MINMAX_EN only)

module temp_bcd_poller #(
  parameter logic [23:0] POLL_DIV = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       start,
  input  logic       done_i,
  input  logic [7:0] msb_i,
  input  logic [7:0] lsb_i,
  input  logic       clr_minmax,
  output logic       sign,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] tenths,
  output logic       valid,
  output logic       timeout,
  output logic       busy,
  output logic [8:0] min_t,
  output logic [8:0] max_t
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    CONV      = 2'd2,
    PRESENT   = 2'd3
  } state_t;

  state_t      state;
  logic [23:0] pcnt;
  logic        tick;

  logic [8:0]  t_new;
  logic [8:0]  mag_new;
  logic        capture;

  logic [8:0]  t_raw;
  logic        half;
  logic [19:0] dd_sr;   // {hund, tens, ones, binary[7:0]}
  logic [2:0]  iter;
  logic        unused_bits;

  // Free-running poll counter; tick marks the last count of each period.
  assign tick = (pcnt == POLL_DIV - 24'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= 24'd0;
    end else if (tick) begin
      pcnt <= 24'd0;
    end else begin
      pcnt <= pcnt + 24'd1;
    end
  end

  // Magnitude of the incoming reading; 9'h100 negates to itself, which read
  // as unsigned is exactly 256, so no extra width is needed.
  assign t_new   = {msb_i, lsb_i[7]};
  assign mag_new = t_new[8] ? (~t_new + 9'd1) : t_new;

  // done_i is accepted only while waiting for a result; in CONV and PRESENT
  // it is dropped so an in-flight conversion is never disturbed.
  assign capture = done_i && ((state == IDLE) || (state == WAIT_DONE));

  assign busy = (state != IDLE);

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] s;
    s = sr;
    if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
    if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
    if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
    return {s[18:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start   <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      sign    <= 1'b0;
      hund    <= 4'd0;
      tens    <= 4'd0;
      ones    <= 4'd0;
      tenths  <= 4'd0;
      t_raw   <= 9'd0;
      half    <= 1'b0;
      dd_sr   <= 20'd0;
      iter    <= 3'd0;
    end else begin
      start   <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;

      if (capture) begin
        // A done coinciding with a tick wins: no start and no timeout.
        t_raw <= t_new;
        half  <= mag_new[0];
        dd_sr <= {12'd0, mag_new[8:1]};
        iter  <= 3'd0;
        state <= CONV;
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              start <= 1'b1;
              state <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            // The tick that ends the wait reports a timeout instead of
            // issuing a new start.
            if (tick) begin
              timeout <= 1'b1;
              state   <= IDLE;
            end
          end
          CONV: begin
            dd_sr <= dd_step(dd_sr);
            iter  <= iter + 3'd1;
            if (iter == 3'd7) begin
              state <= PRESENT;
            end
          end
          PRESENT: begin
            hund   <= dd_sr[19:16];
            tens   <= dd_sr[15:12];
            ones   <= dd_sr[11:8];
            tenths <= half ? 4'd5 : 4'd0;
            sign   <= t_raw[8];
            valid  <= 1'b1;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef TEMP_MINMAX_EN
  logic [8:0] base_min;
  logic [8:0] base_max;

  // A clear coinciding with an update applies first, so the new reading is
  // compared against the reset extremes.
  always_comb begin
    base_min = clr_minmax ? 9'h0FF : min_t;
    base_max = clr_minmax ? 9'h100 : max_t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_t <= 9'h0FF;
      max_t <= 9'h100;
    end else if (state == PRESENT) begin
      min_t <= ($signed(t_raw) < $signed(base_min)) ? t_raw : base_min;
      max_t <= ($signed(t_raw) > $signed(base_max)) ? t_raw : base_max;
    end else if (clr_minmax) begin
      min_t <= 9'h0FF;
      max_t <= 9'h100;
    end
  end

  assign unused_bits = &{1'b0, lsb_i[6:0]};
`else
  assign min_t = 9'h000;
  assign max_t = 9'h000;

  assign unused_bits = &{1'b0, lsb_i[6:0], clr_minmax, t_raw[7:0]};
`endif

endmodule
